// File: rtl/diff_ser_pkg.sv
// Shared types and width helpers for the diff_ser serializer.
// DIFF_SER_PARITY_EN appends an odd-parity bit after the LSB of every word.
package diff_ser_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_t;

`ifdef DIFF_SER_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  // Counter width that never collapses to zero bits for tiny parameters.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int nbits(input int data_width);
    return data_width + PARITY_BITS;
  endfunction

endpackage

// File: rtl/diff_ser_clk_div.sv
// Serial clock generator: CLK_DIV aclk cycles per ser_clk phase, always
// starting with a low phase when run rises.
module diff_ser_clk_div
  import diff_ser_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic run,
  output logic tick,
  output logic ser_clk
);

  localparam int CW = cnt_w(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  // tick marks the last aclk cycle of the current phase
  assign tick = run && (cnt == LAST);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt     <= '0;
      ser_clk <= 1'b0;
    end else if (!run) begin
      cnt     <= '0;
      ser_clk <= 1'b0;
    end else if (tick) begin
      cnt     <= '0;
      ser_clk <= ~ser_clk;
    end else begin
      cnt     <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/diff_ser_tx.sv
// AXI-Stream to source-synchronous serial (clk/data/frame) transmitter, MSB first.
// Define DIFF_SER_PARITY_EN to append an odd-parity bit after each word.
module diff_ser_tx
  import diff_ser_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic                  ser_clk,
  output logic                  ser_data,
  output logic                  ser_frame,
  output logic                  busy
);

  localparam int NBITS = nbits(DATA_WIDTH);
  localparam int BCW   = cnt_w(DATA_WIDTH + 1);
  localparam int GCW   = cnt_w(GAP_CYCLES);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(NBITS - 1);
  localparam logic [GCW-1:0] LAST_GAP = GCW'(GAP_CYCLES - 1);

  state_t           state;
  logic [NBITS-1:0] shreg;
  logic [NBITS-1:0] load_word;
  logic [BCW-1:0]   bit_cnt;
  logic [GCW-1:0]   gap_cnt;
  logic             tick;
  logic             run;

`ifdef DIFF_SER_PARITY_EN
  assign load_word = {s_axis_tdata, ~^s_axis_tdata};
`else
  assign load_word = s_axis_tdata;
`endif

  // The shift register MSB is the pin driver; it is cleared outside SHIFT.
  assign ser_data = shreg[NBITS-1];
  assign run      = (state == SHIFT);

  diff_ser_clk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_div (
    .aclk   (aclk),
    .aresetn(aresetn),
    .run    (run),
    .tick   (tick),
    .ser_clk(ser_clk)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= IDLE;
      shreg         <= '0;
      bit_cnt       <= '0;
      gap_cnt       <= '0;
      s_axis_tready <= 1'b0;
      ser_frame     <= 1'b0;
      busy          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          s_axis_tready <= 1'b1;
          if (s_axis_tvalid && s_axis_tready) begin
            state         <= SHIFT;
            shreg         <= load_word;
            bit_cnt       <= '0;
            s_axis_tready <= 1'b0;
            ser_frame     <= 1'b1;
            busy          <= 1'b1;
          end
        end
        SHIFT: begin
          // A bit ends with the last cycle of its high phase
          if (tick && ser_clk) begin
            if (bit_cnt == LAST_BIT) begin
              state     <= GAP;
              shreg     <= '0;
              gap_cnt   <= '0;
              ser_frame <= 1'b0;
            end else begin
              shreg   <= shreg << 1;
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        GAP: begin
          if (gap_cnt == LAST_GAP) begin
            state         <= IDLE;
            s_axis_tready <= 1'b1;
            busy          <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
